// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage core: per-stage enables and bubbles,
// HALT drain sequencing and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             halt_de,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             mw_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned DW = (DRAIN_CYCLES + 1 > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StRun, StHalting, StHalted} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic pc_c, fd_c, de_c, em_c, mw_c;
  logic fd_fl_c, de_fl_c, mw_fl_c, halted_c;

  always_comb begin
    pc_c     = 1'b1;
    fd_c     = 1'b1;
    de_c     = 1'b1;
    em_c     = 1'b1;
    mw_c     = 1'b1;
    fd_fl_c  = 1'b0;
    de_fl_c  = 1'b0;
    mw_fl_c  = 1'b0;
    halted_c = 1'b0;
    state_d  = state_q;
    drain_d  = drain_q;

    unique case (state_q)
      StRun: begin
        if (dmem_busy) begin
          // Freeze everything upstream of MEM; only MW advances, carrying a bubble.
          pc_c    = 1'b0;
          fd_c    = 1'b0;
          de_c    = 1'b0;
          em_c    = 1'b0;
          mw_fl_c = 1'b1;
        end else if (br_taken) begin
          fd_fl_c = 1'b1;
          de_fl_c = 1'b1;
        end else if (load_use) begin
          pc_c    = 1'b0;
          fd_c    = 1'b0;
          de_fl_c = 1'b1;
        end else if (halt_de) begin
          pc_c    = 1'b0;
          fd_fl_c = 1'b1;
          state_d = StHalting;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else if (imem_busy) begin
          pc_c    = 1'b0;
          fd_fl_c = 1'b1;
        end
      end

      StHalting: begin
        if (dmem_busy) begin
          pc_c    = 1'b0;
          fd_c    = 1'b0;
          de_c    = 1'b0;
          em_c    = 1'b0;
          mw_fl_c = 1'b1;
        end else begin
          pc_c    = 1'b0;
          fd_fl_c = 1'b1;
          de_fl_c = 1'b1;
          if (drain_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end

      StHalted: begin
        pc_c     = 1'b0;
        fd_c     = 1'b0;
        de_c     = 1'b0;
        em_c     = 1'b0;
        mw_c     = 1'b0;
        halted_c = 1'b1;
      end

      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q != StHalted && !pc_c && stall_q != '1) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces every control low, including the RUN defaults.
  assign pc_en        = rst & pc_c;
  assign fd_en        = rst & fd_c;
  assign de_en        = rst & de_c;
  assign em_en        = rst & em_c;
  assign mw_en        = rst & mw_c;
  assign fd_flush     = rst & fd_fl_c;
  assign de_flush     = rst & de_fl_c;
  assign mw_flush     = rst & mw_fl_c;
  assign halted       = rst & halted_c;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl with a cycle-level behavioural reference model.
module tb_pipe_ctrl;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_use = 1'b0, br_taken = 1'b0, halt_de = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, halted;
  logic pc_en4, fd_en4, de_en4, em_en4, mw_en4, fd_flush4, de_flush4, mw_flush4, halted4;
  logic [15:0] stall_cycles;
  logic [3:0]  stall4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .br_taken(br_taken), .halt_de(halt_de),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en),
    .em_en(em_en), .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .mw_flush(mw_flush), .halted(halted), .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut4 (
    .clk(clk), .rst(rst), .load_use(load_use), .br_taken(br_taken), .halt_de(halt_de),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_en(pc_en4), .fd_en(fd_en4),
    .de_en(de_en4), .em_en(em_en4), .mw_en(mw_en4), .fd_flush(fd_flush4),
    .de_flush(de_flush4), .mw_flush(mw_flush4), .halted(halted4), .stall_cycles(stall4)
  );

  // {pc, fd, de, em, mw, fd_flush, de_flush, mw_flush, halted}
  wire [8:0] obs = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, halted};

  localparam logic [8:0] OIdle   = 9'b11111_000_0;
  localparam logic [8:0] OMem    = 9'b00001_001_0;
  localparam logic [8:0] OBranch = 9'b11111_110_0;
  localparam logic [8:0] OLoadU  = 9'b00111_010_0;
  localparam logic [8:0] OFetch  = 9'b01111_100_0;
  localparam logic [8:0] ODrain  = 9'b01111_110_0;
  localparam logic [8:0] OHalted = 9'b00000_000_1;

  // Reference model: mode 0 = running, 1 = draining, 2 = stopped.
  int m_mode = 0, m_left = 0, m_stall = 0, m_stall4 = 0;

  function automatic logic [8:0] model_out(input int mode, input logic lu, br, hd, ib, db);
    if (mode == 2) return OHalted;
    if (db) return OMem;
    if (mode == 1) return ODrain;
    if (br) return OBranch;
    if (lu) return OLoadU;
    if (hd || ib) return OFetch;
    return OIdle;
  endfunction

  wire [8:0] m_exp = model_out(m_mode, load_use, br_taken, halt_de, imem_busy, dmem_busy);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_left <= 0; m_stall <= 0; m_stall4 <= 0;
    end else begin
      if (m_mode != 2 && !m_exp[8]) begin
        if (m_stall < 65535) m_stall <= m_stall + 1;
        if (m_stall4 < 15) m_stall4 <= m_stall4 + 1;
      end
      if (m_mode == 0 && !dmem_busy && !br_taken && !load_use && halt_de) begin
        m_mode <= 1;
        m_left <= DRAIN;
      end else if (m_mode == 1 && !dmem_busy) begin
        if (m_left == 1) m_mode <= 2;
        m_left <= m_left - 1;
      end
    end
  end

  task automatic drive(input logic r, lu, br, hd, ib, db);
    @(negedge clk);
    rst = r; load_use = lu; br_taken = br; halt_de = hd; imem_busy = ib; dmem_busy = db;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (obs !== 9'b0) begin bad++; $display("FAIL reset_outs got=%b want=%b", obs, 9'b0); end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL reset_stall got=%0d want=0", stall_cycles);
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== OIdle) begin bad++; $display("FAIL idle_outs got=%b want=%b", obs, OIdle); end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL idle_stall got=%0d want=0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] st = stall_cycles;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== OLoadU) begin bad++; $display("FAIL load_use got=%b want=%b", obs, OLoadU); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== OIdle) begin bad++; $display("FAIL load_use_after got=%b want=%b", obs, OIdle); end
    total++;
    if (stall_cycles !== st + 16'd1) begin
      bad++; $display("FAIL load_use_stall got=%0d want=%0d", stall_cycles, st + 16'd1);
    end
  endtask

  task automatic test_branch();
    logic [15:0] st = stall_cycles;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs !== OBranch) begin bad++; $display("FAIL branch got=%b want=%b", obs, OBranch); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stall_cycles !== st) begin
      bad++; $display("FAIL branch_stall got=%0d want=%0d", stall_cycles, st);
    end
  endtask

  task automatic test_dmem();
    logic [15:0] st = stall_cycles;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (obs !== OMem) begin bad++; $display("FAIL dmem_c%0d got=%b want=%b", i, obs, OMem); end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== OBranch) begin bad++; $display("FAIL dmem_branch got=%b want=%b", obs, OBranch); end
    total++;
    if (stall_cycles !== st + 16'd3) begin
      bad++; $display("FAIL dmem_stall got=%0d want=%0d", stall_cycles, st + 16'd3);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    int k;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs !== OFetch) begin bad++; $display("FAIL halt_accept got=%b want=%b", obs, OFetch); end
    for (k = 1; k <= 20; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (k <= 2) ? 1'b1 : 1'b0);
      if (halted === 1'b1) break;
    end
    total++;
    if (k !== DRAIN + 3) begin bad++; $display("FAIL halt_latency got=%0d want=%0d", k, DRAIN + 3); end
    total++;
    if (obs !== OHalted) begin bad++; $display("FAIL halted_outs got=%b want=%b", obs, OHalted); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== 9'b0) begin bad++; $display("FAIL halt_rst_outs got=%b want=%b", obs, 9'b0); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== OIdle) begin bad++; $display("FAIL halt_rst_run got=%b want=%b", obs, OIdle); end
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stall4 !== 4'd15) begin bad++; $display("FAIL sat4 got=%0d want=15", stall4); end
    total++;
    if (stall_cycles !== 16'd20) begin bad++; $display("FAIL sat16 got=%0d want=20", stall_cycles); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0) begin bad++; $display("FAIL rnd_rst i=%0d got=%b want=0", i, obs); end
        continue;
      end
      drive(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      total++;
      if (obs !== m_exp) begin bad++; $display("FAIL rnd_outs i=%0d got=%b want=%b", i, obs, m_exp); end
      total++;
      if (int'(stall_cycles) !== m_stall) begin
        bad++; $display("FAIL rnd_stall i=%0d got=%0d want=%0d", i, stall_cycles, m_stall);
      end
      total++;
      if (int'(stall4) !== m_stall4) begin
        bad++; $display("FAIL rnd_stall4 i=%0d got=%0d want=%0d", i, stall4, m_stall4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_dmem();
    test_halt();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
